// File: rtl/ps2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                       |
// | Description : Shared constants, frame-state enum and defaults for the PS/2  |
// |               keyboard receiver.                                            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package ps2_pkg;

  // Scan-code set 2 prefix bytes
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Default build parameters
  localparam int PS2_FILTER_LEN_DEFAULT     = 8;
  localparam int PS2_TIMEOUT_CYCLES_DEFAULT = 50000;

  // Frame reception states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ps2_line_filter                                               |
// | Description : Two-flop synchronizer followed by a glitch filter for one     |
// |               PS/2 line. The filtered output only follows the synchronized  |
// |               input after FILTER_LEN consecutive differing samples.         |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Next-state: synchronizer shift and run-length counter toward a level change
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; an idle PS/2 line is high, so reset to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ps2_receiver                                                  |
// | Description : PS/2 keyboard receiver. Filters the raw lines, assembles      |
// |               11-bit frames, decodes E0/F0 prefixes and publishes key       |
// |               events with a ready/ack handshake toward the MIO bus.         |
// |               Optional macro PS2_PARITY_CHECK_EN enables odd-parity check.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_ready,
  output logic       key_break,
  output logic       key_ext,
  output logic       overflow,
  output logic       frame_err
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT_CYCLES - 1);

  logic clk_filt;
  logic data_filt;
  logic fall;
  logic frame_ok;
  logic byte_stb;
  logic publish;

  logic            clk_prev_q,  clk_prev_d;
  ps2_state_e      state_q,     state_d;
  logic [2:0]      bit_cnt_q,   bit_cnt_d;
  logic [7:0]      shreg_q,     shreg_d;
  logic            parity_q,    parity_d;
  logic [WD_W-1:0] wd_q,        wd_d;
  logic            frame_err_q, frame_err_d;
  logic            ext_pend_q,  ext_pend_d;
  logic            brk_pend_q,  brk_pend_d;
  logic [7:0]      key_code_q,  key_code_d;
  logic            key_break_q, key_break_d;
  logic            key_ext_q,   key_ext_d;
  logic            key_ready_q, key_ready_d;
  logic            overflow_q,  overflow_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_clk),
    .dout (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (ps2_data),
    .dout (data_filt)
  );

  // Falling edge of the filtered PS/2 clock
  assign fall       = clk_prev_q & ~clk_filt;
  assign clk_prev_d = clk_filt;

  // Stop-bit check; the start bit is already known to be 0 because IDLE only
  // leaves on a low data sample
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = data_filt & ps2_odd_parity_ok(shreg_q, parity_q);
`else
    frame_ok = data_filt;
`endif
  end

  // Frame FSM with watchdog; bytes are handed to the decoder on the stop-bit fall
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    wd_d        = wd_q;
    frame_err_d = 1'b0;
    byte_stb    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_filt) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_d = {data_filt, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          parity_d = data_filt;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (frame_ok) begin
            byte_stb = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The watchdog counts cycles since the last fall while a frame is open;
    // the trip fires on the cycle the count would reach TIMEOUT_CYCLES
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (fall) begin
      wd_d = '0;
    end else if (wd_q == WD_TRIP) begin
      wd_d        = '0;
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Prefix decoder and ready/ack/overflow handshake
  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_code_d  = key_code_q;
    key_break_d = key_break_q;
    key_ext_d   = key_ext_q;
    key_ready_d = key_ready_q;
    overflow_d  = overflow_q;
    publish     = 1'b0;

    if (frame_err_d) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_stb) begin
      if (shreg_q == PS2_PREFIX_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == PS2_PREFIX_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        publish     = 1'b1;
        key_code_d  = shreg_q;
        key_break_d = brk_pend_q;
        key_ext_d   = ext_pend_q;
        ext_pend_d  = 1'b0;
        brk_pend_d  = 1'b0;
      end
    end

    // A publish always wins over a coincident ack; it only counts as an
    // overwrite when the previous event was still pending and not being acked
    if (publish) begin
      key_ready_d = 1'b1;
      if (key_ready_q && !key_ack) begin
        overflow_d = 1'b1;
      end
    end else if (key_ack && key_ready_q) begin
      key_ready_d = 1'b0;
      overflow_d  = 1'b0;
    end
  end

  // All receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'd0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      frame_err_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_code_q  <= 8'd0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      key_ready_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      wd_q        <= wd_d;
      frame_err_q <= frame_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_code_q  <= key_code_d;
      key_break_q <= key_break_d;
      key_ext_q   <= key_ext_d;
      key_ready_q <= key_ready_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_ready = key_ready_q;
  assign key_break = key_break_q;
  assign key_ext   = key_ext_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_ps2_receiver                                               |
// | Description : Directed self-checking bench for ps2_receiver.                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_ps2_receiver;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_ready;
  logic       key_break;
  logic       key_ext;
  logic       overflow;
  logic       frame_err;

  int tests  = 0;
  int failed = 0;
  int err_cnt = 0;
  int err_base;

  ps2_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_break (key_break),
    .key_ext   (key_ext),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count every cycle frame_err is high, sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && frame_err) err_cnt = err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the first nbits of an 11-bit frame: start, 8 data LSB first, parity, stop.
  // With ack_at_stop, key_ack is pulsed exactly in the cycle the stop-bit fall is
  // processed (2 + FILTER_LEN cycles after the pin drops).
  task automatic send_frame(input logic [7:0] d, input bit flip_par, input int nbits,
                            input bit ack_at_stop);
    logic [10:0] bits;
    logic        par;
    par  = ~(^d) ^ flip_par;
    bits = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(8);
      ps2_clk = 1'b0;
      if (ack_at_stop && i == 10) begin
        tick(2 + FILTER_LEN);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        tick(5);
      end else begin
        tick(12);
      end
      ps2_clk = 1'b1;
      tick(4);
    end
    ps2_data = 1'b1;
    tick(4);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick(1);
    key_ack = 1'b0;
    tick(1);
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    key_ack  = 1'b0;
    tick(5);

    // Reset state
    check("rst_ready",    {31'd0, key_ready}, 32'd0);
    check("rst_code",     {24'd0, key_code},  32'd0);
    check("rst_break",    {31'd0, key_break}, 32'd0);
    check("rst_ext",      {31'd0, key_ext},   32'd0);
    check("rst_overflow", {31'd0, overflow},  32'd0);
    check("rst_frame_err",{31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(20);

    // Plain make code 1C
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("make_ready", {31'd0, key_ready}, 32'd1);
    check("make_code",  {24'd0, key_code},  32'h1C);
    check("make_break", {31'd0, key_break}, 32'd0);
    check("make_ext",   {31'd0, key_ext},   32'd0);
    check("make_noerr", err_cnt, 32'd0);
    ack_pulse();
    check("ack_ready",  {31'd0, key_ready}, 32'd0);
    check("ack_code",   {24'd0, key_code},  32'h1C);

    // Break: F0 then 1C
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    check("f0_no_event", {31'd0, key_ready}, 32'd0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("brk_ready", {31'd0, key_ready}, 32'd1);
    check("brk_code",  {24'd0, key_code},  32'h1C);
    check("brk_break", {31'd0, key_break}, 32'd1);
    check("brk_ext",   {31'd0, key_ext},   32'd0);
    ack_pulse();

    // Extended break: E0 F0 75
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    check("e0f0_no_event", {31'd0, key_ready}, 32'd0);
    send_frame(8'h75, 1'b0, 11, 1'b0);
    check("ext_code",  {24'd0, key_code},  32'h75);
    check("ext_ext",   {31'd0, key_ext},   32'd1);
    check("ext_break", {31'd0, key_break}, 32'd1);
    ack_pulse();

    // Flipped parity on 1C
    err_base = err_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_err",      err_cnt - err_base, 32'd1);
    check("par_no_ready", {31'd0, key_ready}, 32'd0);
`else
    check("par_ignored_err", err_cnt - err_base, 32'd0);
    check("par_ready",       {31'd0, key_ready}, 32'd1);
    check("par_code",        {24'd0, key_code},  32'h1C);
    check("par_plain",       {30'd0, key_break, key_ext}, 32'd0);
`endif
    ack_pulse();

    // Pending F0, then a truncated frame that times out; the timeout clears the prefix
    send_frame(8'hF0, 1'b0, 11, 1'b0);
    err_base = err_cnt;
    send_frame(8'h32, 1'b0, 4, 1'b0);
    check("to_before", err_cnt - err_base, 32'd0);
    tick(TIMEOUT_CYCLES + 50);
    check("to_err_pulse", err_cnt - err_base, 32'd1);
    check("to_no_ready",  {31'd0, key_ready}, 32'd0);
    send_frame(8'h32, 1'b0, 11, 1'b0);
    check("to_next_ready", {31'd0, key_ready}, 32'd1);
    check("to_next_code",  {24'd0, key_code},  32'h32);
    check("to_prefix_clr", {31'd0, key_break}, 32'd0);
    ack_pulse();

    // Overwrite without ack
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("ov_first_clean", {31'd0, overflow}, 32'd0);
    send_frame(8'h32, 1'b0, 11, 1'b0);
    check("ov_set",   {31'd0, overflow},  32'd1);
    check("ov_code",  {24'd0, key_code},  32'h32);
    check("ov_ready", {31'd0, key_ready}, 32'd1);
    ack_pulse();
    check("ov_ack_ready", {31'd0, key_ready}, 32'd0);
    check("ov_ack_clear", {31'd0, overflow},  32'd0);

    // Publish coincident with ack while an event is pending
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("co_pending", {31'd0, key_ready}, 32'd1);
    send_frame(8'h32, 1'b0, 11, 1'b1);
    check("co_ready",    {31'd0, key_ready}, 32'd1);
    check("co_overflow", {31'd0, overflow},  32'd0);
    check("co_code",     {24'd0, key_code},  32'h32);
    ack_pulse();

    // Reset in the middle of a frame: partial frame dropped, no frame_err
    err_base = err_cnt;
    send_frame(8'h75, 1'b0, 5, 1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(TIMEOUT_CYCLES + 20);
    check("mid_rst_noerr", err_cnt - err_base, 32'd0);
    check("mid_rst_code",  {24'd0, key_code},  32'd0);
    send_frame(8'h1C, 1'b0, 11, 1'b0);
    check("mid_rst_next",  {24'd0, key_code},  32'h1C);
    check("mid_rst_ready", {31'd0, key_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
